// File: rtl/leaky_relu_h_cache_if.sv
// Bus between the forward/backward datapath and the two-column H cache.
// master = upstream driver of capture/replay controls, slave = the cache.
interface leaky_relu_h_cache_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                   cap_start_in;
    logic                   rep_start_in;
    logic                   h_wr_valid_1_in;
    logic                   h_wr_valid_2_in;
    logic [DATA_WIDTH-1:0]  h_1_in;
    logic [DATA_WIDTH-1:0]  h_2_in;
    logic                   h_rd_en_1_in;
    logic                   h_rd_en_2_in;
    logic [DATA_WIDTH-1:0]  h_1_out;
    logic [DATA_WIDTH-1:0]  h_2_out;
    logic                   h_valid_1_out;
    logic                   h_valid_2_out;
    logic [ADDR_WIDTH:0]    count_1_out;
    logic [ADDR_WIDTH:0]    count_2_out;
    logic                   busy_out;
    logic                   replay_done_out;
    logic                   overflow_out;
    logic                   underflow_out;

    modport master (
        output cap_start_in, rep_start_in, h_wr_valid_1_in, h_wr_valid_2_in,
               h_1_in, h_2_in, h_rd_en_1_in, h_rd_en_2_in,
        input  h_1_out, h_2_out, h_valid_1_out, h_valid_2_out, count_1_out,
               count_2_out, busy_out, replay_done_out, overflow_out, underflow_out
    );

    modport slave (
        input  cap_start_in, rep_start_in, h_wr_valid_1_in, h_wr_valid_2_in,
               h_1_in, h_2_in, h_rd_en_1_in, h_rd_en_2_in,
        output h_1_out, h_2_out, h_valid_1_out, h_valid_2_out, count_1_out,
               count_2_out, busy_out, replay_done_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/leaky_relu_h_cache.sv
// Two-lane H activation cache: captures pre-activations in the forward pass and
// replays them in order, one cycle after each read request, for the backward pass.
module leaky_relu_h_cache #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    leaky_relu_h_cache_if.slave    bus
);
    localparam int NL = 2;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_REPLAY  = 2'd2;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [1:0]                         state_q, state_d;
    // No wrap-around, so the write pointer doubles as the lane count.
    logic [NL-1:0][ADDR_WIDTH:0]        cnt_q, cnt_d;
    logic [NL-1:0][ADDR_WIDTH:0]        rd_q, rd_d;
    logic [NL-1:0][DATA_WIDTH-1:0]      h_q, h_d;
    logic [NL-1:0]                      hv_q, hv_d;
    logic                               done_q, done_d;
    logic                               ovf_q, ovf_d;
    logic                               unf_q, unf_d;
    logic [NL-1:0]                      wr_en;
    logic [NL-1:0]                      wv, rd_en;
    logic [NL-1:0][DATA_WIDTH-1:0]      din;
    logic [DATA_WIDTH-1:0]              mem_q [NL][DEPTH];

    assign wv    = {bus.h_wr_valid_2_in, bus.h_wr_valid_1_in};
    assign rd_en = {bus.h_rd_en_2_in, bus.h_rd_en_1_in};
    assign din   = {bus.h_2_in, bus.h_1_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        h_d     = h_q;
        hv_d    = '0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = '0;
        if (bus.cap_start_in) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rep_start_in) begin
                        state_d = S_REPLAY;
                        rd_d    = '0;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < NL; i++) begin
                        if (wv[i]) begin
                            if (cnt_q[i] < FULL) begin
                                wr_en[i] = 1'b1;
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    if (bus.rep_start_in) begin
                        state_d = S_REPLAY;
                        rd_d    = '0;
                    end
                end
                S_REPLAY: begin
                    if (bus.rep_start_in) begin
                        rd_d = '0;
                    end else begin
                        for (int i = 0; i < NL; i++) begin
                            if (rd_en[i]) begin
                                if (rd_q[i] < cnt_q[i]) begin
                                    h_d[i]  = mem_q[i][rd_q[i][ADDR_WIDTH-1:0]];
                                    hv_d[i] = 1'b1;
                                    rd_d[i] = rd_q[i] + 1'b1;
                                end else begin
                                    h_d[i] = '0;
                                    unf_d  = 1'b1;
                                end
                            end
                        end
                        // Done is judged on the pointers as they stood before this edge.
                        if (rd_q == cnt_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            h_q     <= '0;
            hv_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            h_q     <= h_d;
            hv_q    <= hv_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage survives reset; zeroed counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (rst && wr_en[i]) mem_q[i][cnt_q[i][ADDR_WIDTH-1:0]] <= din[i];
        end
    end

    assign bus.h_1_out         = h_q[0];
    assign bus.h_2_out         = h_q[1];
    assign bus.h_valid_1_out   = hv_q[0];
    assign bus.h_valid_2_out   = hv_q[1];
    assign bus.count_1_out     = cnt_q[0];
    assign bus.count_2_out     = cnt_q[1];
    assign bus.busy_out        = (state_q != S_IDLE);
    assign bus.replay_done_out = done_q;
    assign bus.overflow_out    = ovf_q;
    assign bus.underflow_out   = unf_q;
endmodule

// File: doc/leaky_relu_h_cache.md
Name: leaky_relu_h_cache

Overview:
- Two-column activation cache that sits between the forward-pass systolic output and the backward-pass leaky-ReLU derivative stage.
- During capture it records each column's pre-activation values H.
- During replay it returns those values in arrival order, so H reaches the derivative children on the same cycle as the matching gradient.
- It is the writer/reader counterpart that feeds the derivative stage's H inputs.

Parameters:
DATA_WIDTH, 16, width of H samples (signed Q8.8)
DEPTH, 16, entries per column lane (power of two)
ADDR_WIDTH, 4, log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a clk edge resets)
cap_start_in  input  1  pulse: enter CAPTURE, clear both lanes
rep_start_in  input  1  pulse: enter REPLAY, rewind read pointers
h_wr_valid_1_in  input  1  column-1 H sample valid (CAPTURE only)
h_wr_valid_2_in  input  1  column-2 H sample valid (CAPTURE only)
h_1_in  input  DATA_WIDTH  column-1 H sample, signed
h_2_in  input  DATA_WIDTH  column-2 H sample, signed
h_rd_en_1_in  input  1  column-1 read request (REPLAY only)
h_rd_en_2_in  input  1  column-2 read request (REPLAY only)
h_1_out  output  DATA_WIDTH  column-1 replayed H, signed
h_2_out  output  DATA_WIDTH  column-2 replayed H, signed
h_valid_1_out  output  1  h_1_out valid
h_valid_2_out  output  1  h_2_out valid
count_1_out  output  ADDR_WIDTH+1  entries held, column 1
count_2_out  output  ADDR_WIDTH+1  entries held, column 2
busy_out  output  1  state != IDLE
replay_done_out  output  1  one-cycle pulse when replay completes
overflow_out  output  1  sticky: write attempted while lane full
underflow_out  output  1  sticky: read attempted past lane count

Behaviour:
- Reset (rst==0 at an edge):
  - State goes to IDLE; write/read pointers, counts, all outputs and flags go to 0.
  - Memory contents are not cleared.
  - Reset mid-capture or mid-replay aborts immediately; the previous contents are unreachable because counts are 0.
- States: IDLE, CAPTURE, REPLAY (2-bit register).
- IDLE:
  - cap_start_in -> CAPTURE. Clears wr_ptr, count, rd_ptr and both sticky flags.
  - rep_start_in -> REPLAY. Sets rd_ptr_1/2 to 0; counts are kept, so replay is repeatable.
- CAPTURE:
  - h_wr_valid_x_in with count_x<DEPTH: writes h_x_in at wr_ptr_x, then wr_ptr_x++ and count_x++.
  - count_x==DEPTH: write dropped, overflow_out set.
  - Lanes are independent; both may write in the same cycle.
  - Read enables are ignored.
  - rep_start_in -> REPLAY, rewinding read pointers. A write in that same cycle is still accepted.
  - cap_start_in re-clears the lanes and stays in CAPTURE.
- REPLAY:
  - h_rd_en_x_in with rd_ptr_x<count_x: the next cycle gives h_x_out=mem_x[rd_ptr_x] and h_valid_x_out=1, then rd_ptr_x++. Latency is exactly 1 cycle; upstream asserts rd_en one cycle before the matching gradient valid.
  - rd_ptr_x==count_x: the next cycle gives h_valid_x_out=0, h_x_out=0, and underflow_out is set.
  - With no read, h_valid_x_out=0 and h_x_out holds its last value.
  - Write valids are ignored.
  - Completion: when rd_ptr_1==count_1 and rd_ptr_2==count_2, replay_done_out pulses for 1 cycle and state returns to IDLE on the same edge.
  - Entering REPLAY with both counts 0 gives a done pulse one cycle after entry.
  - rep_start_in in REPLAY rewinds the pointers.
  - cap_start_in in REPLAY -> CAPTURE with clear.
- Simultaneous cap_start_in and rep_start_in: cap_start_in wins.
- Ordering: FIFO per lane; no wrap-around. The pointer never exceeds DEPTH; count saturates at DEPTH.
- busy_out is combinational from state. All other outputs are registered.

Test Plan:
- Capture/replay order: cap_start; lane1 writes 0x0100,0xFF00,0x0080; lane2 writes 0x0200,0x0040; rep_start; rd_en both each cycle -> h_1_out 0x0100,0xFF00,0x0080 and h_2_out 0x0200,0x0040, each 1 cycle after rd_en. valid_2 drops after 2 reads. replay_done_out pulses when lane1 exhausts. State returns to IDLE.
- Overflow: DEPTH=16, 17 writes on lane1 -> count_1_out=16, overflow_out=1, entry 17 discarded. Replay returns only the first 16 values.
- Underflow: 2 entries, 3 rd_en on lane1 (lane2 has 3 entries) -> 3rd read gives h_valid_1_out=0, h_1_out=0, underflow_out=1. No done until lane2 is also drained.
- Repeat replay: after done, rep_start again from IDLE -> identical sequence reproduced; counts unchanged.
- Simultaneous starts and reset: cap_start and rep_start in the same cycle -> CAPTURE with counts 0. rst=0 mid-replay -> next cycle state IDLE, all outputs 0, busy_out=0.
- Empty replay: rep_start with both counts 0 -> replay_done_out=1 on the next cycle, no valid outputs.
